// File: rtl/sdr_rx_pkg.sv
// Shared definitions for the SDR receive gearbox: alignment FSM states,
// the default training pattern and counter widths.
package sdr_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    localparam logic [7:0] DEF_TRAIN_WORD  = 8'hA5;

    localparam int MAX_GEAR        = 8;
    localparam int MAX_TRAIN_COUNT = 15;

    localparam int LANE_CNT_W  = $clog2(MAX_GEAR);
    localparam int MATCH_CNT_W = $clog2(MAX_TRAIN_COUNT + 1);
    localparam int ERR_CNT_W   = 16;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sdr_rx_gear_gearbox.sv
// Lane assembler: packs GEAR captured samples into one word, oldest sample
// in the least-significant lane, and presents it on q with a one-cycle strobe.
// The lane counter is exported only when SDR_RX_ERRCNT_EN is defined.
module sdr_rx_gearbox
    import sdr_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GEAR  = 2
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    sample_vld,
    input  logic [WIDTH-1:0]        cap,
    input  logic                    lane_clr,
    input  logic                    emit_en,
`ifdef SDR_RX_ERRCNT_EN
    output logic [LANE_CNT_W-1:0]   lane_cnt,
`endif
    output logic [WIDTH*GEAR-1:0]   q,
    output logic                    q_valid
);

    logic [LANE_CNT_W-1:0]         lane_q, lane_d;
    logic [GEAR-1:0][WIDTH-1:0]    asm_q, asm_d;
    logic                          full_q, full_d;
    logic [WIDTH*GEAR-1:0]         q_q, q_d;
    logic                          q_valid_q, q_valid_d;

    // Write the captured sample into its lane, flag a complete word, and
    // publish the previously completed word one edge later.
    always_comb begin
        lane_d    = lane_q;
        asm_d     = asm_q;
        full_d    = full_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        if (en) begin
            full_d    = 1'b0;
            q_valid_d = 1'b0;
            if (full_q && emit_en) begin
                q_d       = asm_q;
                q_valid_d = 1'b1;
            end
            if (lane_clr) begin
                lane_d = '0;
            end else if (sample_vld) begin
                for (int i = 0; i < GEAR; i++) begin
                    if (lane_q == LANE_CNT_W'(i)) begin
                        asm_d[i] = cap;
                    end
                end
                if (lane_q == LANE_CNT_W'(GEAR - 1)) begin
                    lane_d = '0;
                    full_d = emit_en;
                end else begin
                    lane_d = lane_q + LANE_CNT_W'(1);
                end
            end
        end
    end

    // Gearbox state registers.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lane_q    <= '0;
            asm_q     <= '0;
            full_q    <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            asm_q     <= asm_d;
            full_q    <= full_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q       = q_q;
    // A held strobe stays invisible while the enable is low.
    assign q_valid = q_valid_q & en;
`ifdef SDR_RX_ERRCNT_EN
    assign lane_cnt = lane_q;
`endif

endmodule

// File: rtl/sdr_rx_gear.sv
// SDR input capture with gearing and training-pattern word alignment.
// Optional slip counter output err_cnt is built when SDR_RX_ERRCNT_EN is defined.
module sdr_rx_gear
    import sdr_rx_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               GEAR        = 2,
    parameter logic [WIDTH-1:0] TRAIN_WORD  = WIDTH'(DEF_TRAIN_WORD),
    parameter int               TRAIN_COUNT = 4,
    parameter int               TIMEOUT     = 256
) (
    input  logic                    clkin,
    input  logic                    reset,
    output logic                    sclk,
    input  logic                    en,
    input  logic [WIDTH-1:0]        datain,
    input  logic                    align_req,
    output logic [WIDTH*GEAR-1:0]   q,
    output logic                    q_valid,
    output logic                    locked,
`ifdef SDR_RX_ERRCNT_EN
    output logic [ERR_CNT_W-1:0]    err_cnt,
`endif
    output logic                    align_fail
);

    localparam int TMO_W = cnt_width(TIMEOUT - 1);

    logic [WIDTH-1:0]       cap_q, cap_d;
    logic                   cap_vld_q, cap_vld_d;
    rx_state_e              state_q, state_d;
    logic [MATCH_CNT_W-1:0] match_q, match_d, match_next;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   align_fail_q, align_fail_d;
    logic                   hit;
    logic                   lane_clr;
    logic                   emit_en;
`ifdef SDR_RX_ERRCNT_EN
    logic [LANE_CNT_W-1:0]  lane_cnt;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
`endif

    assign sclk = clkin;

    // Stage 1 capture; the valid flag keeps the reset value of the capture
    // register from being packed into the first word.
    always_comb begin
        cap_d     = cap_q;
        cap_vld_d = cap_vld_q;
        if (en) begin
            cap_d     = datain;
            cap_vld_d = 1'b1;
        end
    end

    // Alignment FSM: count consecutive training words, lock or time out.
    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        tmo_d        = tmo_q;
        align_fail_d = align_fail_q;
        lane_clr     = 1'b0;
        hit          = cap_vld_q && (cap_q == TRAIN_WORD);
        match_next   = '0;
        if (hit) begin
            match_next = (match_q == '1) ? match_q : match_q + MATCH_CNT_W'(1);
        end
        if (en) begin
            align_fail_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (align_req) begin
                        state_d  = SEEK;
                        match_d  = '0;
                        tmo_d    = '0;
                        lane_clr = 1'b1;
                    end
                end
                SEEK: begin
                    if (align_req) begin
                        match_d  = '0;
                        tmo_d    = '0;
                        lane_clr = 1'b1;
                    end else if (match_next >= MATCH_CNT_W'(TRAIN_COUNT)) begin
                        state_d  = LOCKED;
                        match_d  = '0;
                        tmo_d    = '0;
                        lane_clr = 1'b1;
                    end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
                        state_d      = IDLE;
                        align_fail_d = 1'b1;
                        match_d      = '0;
                        tmo_d        = '0;
                    end else begin
                        match_d = match_next;
                        tmo_d   = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
                    end
                end
                LOCKED: begin
                    if (align_req) begin
                        state_d  = SEEK;
                        match_d  = '0;
                        tmo_d    = '0;
                        lane_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Words are only published when the FSM will not be seeking next cycle,
    // so a partial word is dropped as soon as alignment restarts.
    assign emit_en = (state_d != SEEK);

    // Capture and FSM registers.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cap_q        <= '0;
            cap_vld_q    <= 1'b0;
            state_q      <= IDLE;
            match_q      <= '0;
            tmo_q        <= '0;
            align_fail_q <= 1'b0;
        end else begin
            cap_q        <= cap_d;
            cap_vld_q    <= cap_vld_d;
            state_q      <= state_d;
            match_q      <= match_d;
            tmo_q        <= tmo_d;
            align_fail_q <= align_fail_d;
        end
    end

    sdr_rx_gearbox #(
        .WIDTH (WIDTH),
        .GEAR  (GEAR)
    ) u_gearbox (
        .clkin      (clkin),
        .reset      (reset),
        .en         (en),
        .sample_vld (cap_vld_q),
        .cap        (cap_q),
        .lane_clr   (lane_clr),
        .emit_en    (emit_en),
`ifdef SDR_RX_ERRCNT_EN
        .lane_cnt   (lane_cnt),
`endif
        .q          (q),
        .q_valid    (q_valid)
    );

`ifdef SDR_RX_ERRCNT_EN
    // Slip counter: a training word landing on a non-zero lane while locked.
    always_comb begin
        err_d = err_q;
        if (en) begin
            if (align_req) begin
                err_d = '0;
            end else if (state_q == LOCKED && hit && lane_cnt != '0 && err_q != '1) begin
                err_d = err_q + ERR_CNT_W'(1);
            end
        end
    end

    // Slip counter register.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`endif

    assign locked     = (state_q == LOCKED);
    assign align_fail = align_fail_q & en;

endmodule

// File: tb/tb_sdr_rx_gear.sv
// Directed bench for sdr_rx_gear at WIDTH=8, GEAR=2, TRAIN_COUNT=4, TIMEOUT=256.
// Slip counter checks are compiled in when SDR_RX_ERRCNT_EN is defined.
module tb_sdr_rx_gear;

    logic        clkin;
    logic        reset;
    logic        sclk;
    logic        en;
    logic [7:0]  datain;
    logic        align_req;
    logic [15:0] q;
    logic        q_valid;
    logic        locked;
    logic        align_fail;
`ifdef SDR_RX_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    sdr_rx_gear dut (
        .clkin      (clkin),
        .reset      (reset),
        .sclk       (sclk),
        .en         (en),
        .datain     (datain),
        .align_req  (align_req),
        .q          (q),
        .q_valid    (q_valid),
        .locked     (locked),
`ifdef SDR_RX_ERRCNT_EN
        .err_cnt    (err_cnt),
`endif
        .align_fail (align_fail)
    );

    // Free-running input pad clock.
    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, settle 1 time unit after it.
    task automatic applyStimulus(input logic [7:0] d, input logic req, input logic e);
        datain    = d;
        align_req = req;
        en        = e;
        @(posedge clkin);
        #1;
        align_req = 1'b0;
    endtask

    // Main directed sequence.
    initial begin
        int qvCount;
        int failAt;
        int failCount;
        int qvSeek;
        int qvAfter;
        logic [7:0] lockSeq [9];
        logic [7:0] brokenSeq [9];

        reset     = 1'b1;
        en        = 1'b1;
        datain    = 8'h00;
        align_req = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        checkOutput("reset_q", 32'(q), 32'h0);
        checkOutput("reset_qv", 32'(q_valid), 32'h0);
        checkOutput("reset_locked", 32'(locked), 32'h0);
        checkOutput("reset_fail", 32'(align_fail), 32'h0);
        checkOutput("sclk_fwd", 32'(sclk), 32'(clkin));
        reset = 1'b0;

        // Free-running gearing in IDLE.
        applyStimulus(8'h01, 1'b0, 1'b1);
        applyStimulus(8'h02, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("free_qv_early", 32'(q_valid), 32'h0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("free_q", 32'(q), 32'h0201);
        checkOutput("free_qv", 32'(q_valid), 32'h1);
        checkOutput("free_locked", 32'(locked), 32'h0);

        // Lock: request, 3x00, 4xA5, then the first aligned word 11,22.
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkOutput("seek_qv_entry", 32'(q_valid), 32'h0);
        lockSeq = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h11, 8'h22};
        qvCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(lockSeq[i], 1'b0, 1'b1);
            if (q_valid) qvCount++;
            if (i == 6) checkOutput("lock_not_yet", 32'(locked), 32'h0);
        end
        checkOutput("lock_locked", 32'(locked), 32'h1);
        checkOutput("lock_no_qv_seek", 32'(qvCount), 32'h0);
        applyStimulus(lockSeq[8], 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("lock_qv_early", 32'(q_valid), 32'h0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("lock_q", 32'(q), 32'h2211);
        checkOutput("lock_qv", 32'(q_valid), 32'h1);

        // Training words on lane 1 while locked (two of them land there).
        for (int i = 0; i < 4; i++) applyStimulus(8'hA5, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
`ifdef SDR_RX_ERRCNT_EN
        checkOutput("err_cnt_two", 32'(err_cnt), 32'h2);
`endif
        checkOutput("slip_still_locked", 32'(locked), 32'h1);

        // Broken training run: 3xA5, 00, 4xA5 -> lock only after second run.
        applyStimulus(8'h00, 1'b1, 1'b1);
        checkOutput("relock_drop", 32'(locked), 32'h0);
        checkOutput("relock_qv", 32'(q_valid), 32'h0);
`ifdef SDR_RX_ERRCNT_EN
        checkOutput("err_cnt_clear", 32'(err_cnt), 32'h0);
`endif
        brokenSeq = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h33};
        qvCount = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(brokenSeq[i], 1'b0, 1'b1);
            if (q_valid) qvCount++;
            if (i == 4) checkOutput("broken_no_early_lock", 32'(locked), 32'h0);
            if (i == 7) checkOutput("broken_not_yet", 32'(locked), 32'h0);
        end
        checkOutput("broken_locked", 32'(locked), 32'h1);
        checkOutput("broken_no_qv_seek", 32'(qvCount), 32'h0);

        // Enable gap in the middle of a word.
        applyStimulus(8'h44, 1'b0, 1'b1);
        applyStimulus(8'h55, 1'b0, 1'b1);
        applyStimulus(8'h66, 1'b0, 1'b1);
        checkOutput("pre_gap_q", 32'(q), 32'h4433);
        checkOutput("pre_gap_qv", 32'(q_valid), 32'h1);
        qvCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'hFF, 1'b0, 1'b0);
            if (q_valid) qvCount++;
        end
        checkOutput("gap_q_hold", 32'(q), 32'h4433);
        checkOutput("gap_no_qv", 32'(qvCount), 32'h0);
        applyStimulus(8'h77, 1'b0, 1'b1);
        checkOutput("post_gap_qv_early", 32'(q_valid), 32'h0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("post_gap_q", 32'(q), 32'h6655);
        checkOutput("post_gap_qv", 32'(q_valid), 32'h1);

        // Asynchronous reset mid-word while locked.
        applyStimulus(8'h00, 1'b0, 1'b1);
        reset = 1'b1;
        #2;
        checkOutput("async_q", 32'(q), 32'h0);
        checkOutput("async_qv", 32'(q_valid), 32'h0);
        checkOutput("async_locked", 32'(locked), 32'h0);
        checkOutput("async_fail", 32'(align_fail), 32'h0);
        repeat (2) @(posedge clkin);
        #1;
        reset = 1'b0;

        // Timeout: constant 00 never matches the training word.
        applyStimulus(8'h00, 1'b1, 1'b1);
        failAt    = -1;
        failCount = 0;
        qvSeek    = 0;
        qvAfter   = 0;
        for (int n = 1; n <= 300; n++) begin
            applyStimulus(8'h00, 1'b0, 1'b1);
            if (align_fail) begin
                failCount++;
                if (failAt < 0) failAt = n;
            end
            if (q_valid) begin
                if (failAt < 0) qvSeek++;
                else qvAfter++;
            end
        end
        checkOutput("tmo_fail_cycle", 32'(failAt), 32'd256);
        checkOutput("tmo_fail_width", 32'(failCount), 32'd1);
        checkOutput("tmo_no_qv_seek", 32'(qvSeek), 32'd0);
        checkOutput("tmo_idle_qv", 32'(qvAfter > 0), 32'd1);
        checkOutput("tmo_locked", 32'(locked), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
